mod_updown_counter: RTL

Parameterised up/down counter with programmable modulus, per-cycle step size, three counting modes (wrap, saturate, one-shot), synchronous load, sticky overflow and cascadable active-low carry. It is the general-purpose successor to the team's fixed power-of-two two-way counter. It is intended for timers, decade/BCD chains and rate dividers throughout the design.

---
 rtl/counter_pkg.sv | 16 +
 rtl/mod_step_calc.sv | 80 ++++++++
 rtl/mod_updown_counter.sv | 107 ++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared types for the up/down counter family.
package counter_pkg;

  typedef enum logic [1:0] {
    CM_WRAP,
    CM_SATURATE,
    CM_ONESHOT,
    CM_RSVD
  } count_mode_t;

  typedef enum logic {
    ST_RUN,
    ST_DONE
  } fsm_state_t;

endpackage

// File: rtl/mod_step_calc.sv
// Combinational next-count and wrap/clamp event for one advance of size s.
module mod_step_calc
  import counter_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned MODULUS = 2 ** N
) (
  input  logic [N-1:0] q,
  input  logic [N-1:0] s,
  input  logic         up,
  input  logic [1:0]   mode,
  output logic [N-1:0] q_next,
  output logic         evt
);

  localparam int unsigned W = N + 1;
  localparam logic [W-1:0] MOD_W = W'(MODULUS);
  localparam logic [W-1:0] TOP_W = W'(MODULUS - 1);

  count_mode_t  cmode;
  logic [W-1:0] qw;
  logic [W-1:0] sw;
  logic [W-1:0] sum;
  logic [W-1:0] diff;
  logic [W-1:0] wrap_up;
  logic [W-1:0] wrap_dn;
  logic         borrow;

  assign cmode   = count_mode_t'(mode);
  assign qw      = {1'b0, q};
  assign sw      = {1'b0, s};
  assign sum     = qw + sw;
  assign diff    = qw - sw;
  assign borrow  = (qw < sw);
  assign wrap_up = sum - MOD_W;
  assign wrap_dn = qw + MOD_W - sw;

  // ONESHOT shares the saturating arithmetic; reserved mode wraps.
  always_comb begin
    q_next = q;
    evt    = 1'b0;
    case (cmode)
      CM_SATURATE, CM_ONESHOT: begin
        if (up) begin
          if (sum > TOP_W) begin
            q_next = N'(TOP_W);
            evt    = 1'b1;
          end else begin
            q_next = N'(sum);
          end
        end else begin
          if (borrow) begin
            q_next = '0;
            evt    = 1'b1;
          end else begin
            q_next = N'(diff);
          end
        end
      end
      default: begin
        if (up) begin
          if (sum >= MOD_W) begin
            q_next = N'(wrap_up);
            evt    = 1'b1;
          end else begin
            q_next = N'(sum);
          end
        end else begin
          if (borrow) begin
            q_next = N'(wrap_dn);
            evt    = 1'b1;
          end else begin
            q_next = N'(diff);
          end
        end
      end
    endcase
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Up/down counter with programmable modulus, step, wrap/saturate/one-shot
// modes, synchronous load, sticky overflow and active-low cascade carry.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned MODULUS = 2 ** N
) (
  input  logic         clock,
  input  logic         reset_b,
  input  logic         enable_b,
  input  logic         carry_in_b,
  input  logic         up,
  input  logic [N-1:0] step,
  input  logic [1:0]   mode,
  input  logic         load_b,
  input  logic [N-1:0] load_value,
  input  logic         clear_ovf_b,
  output logic [N-1:0] q,
  output logic         carry_b,
  output logic         ovf,
  output logic         done
);

  localparam logic [N-1:0] TOP     = N'(MODULUS - 1);
  localparam int unsigned  MOD_MAX = 1 << N;
  localparam logic [N:0]   MOD_W   = (N + 1)'(MODULUS);
  localparam bit           MOD_OK  = (MODULUS >= 32'd2) && (MODULUS <= MOD_MAX);

  fsm_state_t   state;
  fsm_state_t   state_nxt;
  count_mode_t  cmode;
  logic [N-1:0] s;
  logic [N-1:0] q_calc;
  logic [N-1:0] q_nxt;
  logic [N-1:0] term;
  logic         evt;
  logic         advance;
  logic         ovf_nxt;
  logic         done_nxt;

  assign cmode   = count_mode_t'(mode);
  assign s       = (step > TOP) ? TOP : step;
  assign term    = up ? TOP : '0;
  assign advance = ~enable_b & ~carry_in_b & load_b & (state == ST_RUN);

  mod_step_calc #(
    .N       (N),
    .MODULUS (MODULUS)
  ) u_step_calc (
    .q      (q),
    .s      (s),
    .up     (up),
    .mode   (mode),
    .q_next (q_calc),
    .evt    (evt)
  );

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state <= ST_RUN;
      q     <= '0;
      ovf   <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      q     <= q_nxt;
      ovf   <= ovf_nxt;
      done  <= done_nxt;
    end
  end

  // Load beats everything; DONE holds q and only leaves on load or mode change.
  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    ovf_nxt   = ovf;
    done_nxt  = 1'b0;
    if (!load_b) begin
      q_nxt     = (load_value > TOP) ? TOP : load_value;
      state_nxt = ST_RUN;
    end else if (state == ST_DONE) begin
      if (cmode != CM_ONESHOT) begin
        state_nxt = ST_RUN;
      end
    end else if (advance) begin
      q_nxt = q_calc;
      if (cmode == CM_ONESHOT && q_calc == term) begin
        state_nxt = ST_DONE;
      end
    end
    done_nxt = (state_nxt == ST_DONE);
    if (advance && evt) begin
      ovf_nxt = 1'b1;
    end else if (!clear_ovf_b) begin
      ovf_nxt = 1'b0;
    end
  end

  assign carry_b = ~(~enable_b & ~carry_in_b &
                     ((up & (q == TOP)) | (~up & (q == '0))));

  a_modulus_legal: assert property (@(posedge clock) MOD_OK);
  a_q_in_range:    assert property (@(posedge clock) disable iff (!reset_b)
                                    ({1'b0, q} < MOD_W));

endmodule
